// File: rtl/mtm_riscv_soc_pkg.sv
// Shared SoC interconnect definitions: data-bus slave encoding used by the
// address decoder and the response router, plus router FSM states.
package mtm_riscv_soc_pkg;

    localparam int DATA_BUS_NUM_SLAVES = 8;
    localparam int DATA_BUS_TIMEOUT    = 64;

    // Value 0 means "no request or unmapped"; slave index is value - 1.
    typedef enum logic [3:0] {
        DATA_BUS_NONE     = 4'd0,
        DATA_BUS_BOOT_ROM = 4'd1,
        DATA_BUS_CODE_RAM = 4'd2,
        DATA_BUS_DATA_RAM = 4'd3,
        DATA_BUS_GPIO     = 4'd4,
        DATA_BUS_SPI      = 4'd5,
        DATA_BUS_UART     = 4'd6,
        DATA_BUS_TIMER    = 4'd7,
        DATA_BUS_PMC      = 4'd8
    } data_bus_slave_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_RESP = 2'd1,
        ERR_RESP  = 2'd2
    } data_bus_router_state_t;

    function automatic logic [3:0] slave_index(input data_bus_slave_t s);
        return 4'(s) - 4'd1;
    endfunction

endpackage

// File: rtl/data_bus_timeout_counter.sv
// Saturating cycle counter guarding the wait for a slave response.
// expired is high while the count sits at TIMEOUT-1.
module data_bus_timeout_counter
    import mtm_riscv_soc_pkg::*;
#(
    parameter int TIMEOUT = DATA_BUS_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable && (count != LIMIT)) begin
            count <= count + CW'(1);
        end
    end

    assign expired = (count == LIMIT);

endmodule

// File: rtl/data_bus_resp_router.sv
// Forwards the core data request to the decoded slave, returns its grant and
// response, and synthesises error responses for unmapped or stalled accesses.
module data_bus_resp_router
    import mtm_riscv_soc_pkg::*;
#(
    parameter int NUM_SLAVES = DATA_BUS_NUM_SLAVES,
    parameter int TIMEOUT    = DATA_BUS_TIMEOUT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  data_bus_slave_t        requested_slave,
    input  logic                   core_req,
    output logic                   core_gnt,
    output logic                   core_rvalid,
    output logic [31:0]            core_rdata,
    output logic                   core_err,
    output logic [NUM_SLAVES-1:0]  slave_req,
    input  logic [NUM_SLAVES-1:0]  slave_gnt,
    input  logic [NUM_SLAVES-1:0]  slave_rvalid,
    input  logic [31:0]            slave_rdata [NUM_SLAVES],
    output logic                   timeout_seen,
    output data_bus_router_state_t state
);

    // Handshake: a request is accepted in the cycle core_req && core_gnt; its
    // single response is the one cycle where core_rvalid is high (core_err and
    // core_rdata are only meaningful then). One transaction is outstanding at most.

    localparam int IW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

    data_bus_router_state_t state_next;
    logic [IW-1:0]          idx;
    logic [IW-1:0]          sel_idx;
    logic                   sel_valid;
    logic                   take_grant;
    logic                   timeout_hit;
    logic                   cnt_enable;
    logic                   expired;

    assign sel_valid = (requested_slave != DATA_BUS_NONE) &&
                       (int'(requested_slave) <= NUM_SLAVES);
    assign sel_idx   = IW'(slave_index(requested_slave));

    // The counter reads 0 whenever it is not counting, so it is already clear in
    // the grant cycle; counting that cycle makes the count equal cycles-since-grant.
    data_bus_timeout_counter #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (!cnt_enable),
        .enable  (cnt_enable),
        .expired (expired)
    );

    always_comb begin
        state_next  = state;
        slave_req   = '0;
        core_gnt    = 1'b0;
        core_rvalid = 1'b0;
        core_err    = 1'b0;
        core_rdata  = 32'h0;
        cnt_enable  = 1'b0;
        take_grant  = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            IDLE: begin
                if (core_req) begin
                    if (sel_valid) begin
                        slave_req[sel_idx] = 1'b1;
                        core_gnt           = slave_gnt[sel_idx];
                        if (slave_gnt[sel_idx]) begin
                            take_grant = 1'b1;
                            cnt_enable = 1'b1;
                            state_next = WAIT_RESP;
                        end
                    end else begin
                        core_gnt   = 1'b1;
                        state_next = ERR_RESP;
                    end
                end
            end
            WAIT_RESP: begin
                // A real response beats a timeout landing in the same cycle.
                if (slave_rvalid[idx]) begin
                    core_rvalid = 1'b1;
                    core_rdata  = slave_rdata[idx];
                    state_next  = IDLE;
                end else if (expired) begin
                    core_rvalid = 1'b1;
                    core_err    = 1'b1;
                    timeout_hit = 1'b1;
                    state_next  = IDLE;
                end else begin
                    cnt_enable = 1'b1;
                end
            end
            ERR_RESP: begin
                core_rvalid = 1'b1;
                core_err    = 1'b1;
                state_next  = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            idx          <= '0;
            timeout_seen <= 1'b0;
        end else begin
            state <= state_next;
            if (take_grant) begin
                idx <= sel_idx;
            end
            if (timeout_hit) begin
                timeout_seen <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_data_bus_resp_router.sv
// Self-checking bench for data_bus_resp_router: directed vector table,
// hand-written timeout/reset sequences, then random traffic against a model.
module tb_data_bus_resp_router;
    import mtm_riscv_soc_pkg::*;

    localparam int NS = 8;
    localparam int TO = 8;

    logic                   clk = 1'b0;
    logic                   rst;
    data_bus_slave_t        requested_slave;
    logic                   core_req;
    logic                   core_gnt;
    logic                   core_rvalid;
    logic [31:0]            core_rdata;
    logic                   core_err;
    logic [NS-1:0]          slave_req;
    logic [NS-1:0]          slave_gnt;
    logic [NS-1:0]          slave_rvalid;
    logic [31:0]            slave_rdata [NS];
    logic                   timeout_seen;
    data_bus_router_state_t state;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [32:0] exp_q[$];

    data_bus_resp_router #(.NUM_SLAVES(NS), .TIMEOUT(TO)) dut (
        .clk             (clk),
        .rst             (rst),
        .requested_slave (requested_slave),
        .core_req        (core_req),
        .core_gnt        (core_gnt),
        .core_rvalid     (core_rvalid),
        .core_rdata      (core_rdata),
        .core_err        (core_err),
        .slave_req       (slave_req),
        .slave_gnt       (slave_gnt),
        .slave_rvalid    (slave_rvalid),
        .slave_rdata     (slave_rdata),
        .timeout_seen    (timeout_seen),
        .state           (state)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1);
    end

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // driver tasks
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic r, input logic q, input data_bus_slave_t s,
                         input logic [7:0] g, input logic [7:0] rv,
                         input int rd_idx, input logic [31:0] rd);
        rst             = r;
        core_req        = q;
        requested_slave = s;
        slave_gnt       = g;
        slave_rvalid    = rv;
        for (int i = 0; i < NS; i++) begin
            slave_rdata[i] = (i == rd_idx) ? rd : (32'hDEAD_0000 | 32'(i));
        end
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, DATA_BUS_NONE, 8'h00, 8'h00, 0, 32'h0);
    endtask

    task automatic check_outs(input string tag, input logic g, input logic [7:0] sr,
                              input logic rv, input logic er, input logic [31:0] rd,
                              input logic ts);
        #1;
        chk({tag, ".gnt"},       32'(core_gnt),     32'(g));
        chk({tag, ".slave_req"}, 32'(slave_req),    32'(sr));
        chk({tag, ".rvalid"},    32'(core_rvalid),  32'(rv));
        chk({tag, ".err"},       32'(core_err),     32'(er));
        chk({tag, ".rdata"},     core_rdata,        rd);
        chk({tag, ".timeout"},   32'(timeout_seen), 32'(ts));
    endtask

    typedef struct {
        logic            req;
        data_bus_slave_t sel;
        logic [7:0]      gnt;
        logic [7:0]      rv;
        int              rd_idx;
        logic [31:0]     rd;
        logic            e_gnt;
        logic [7:0]      e_sreq;
        logic            e_rv;
        logic            e_err;
        logic [31:0]     e_rd;
    } vec_t;

    vec_t vecs[$];

    // reference model state: cycles since grant, sticky timeout, pending error
    bit m_busy;
    int m_idx;
    int m_age;
    bit m_errp;
    bit m_ts;

    initial begin
        // reset
        drive(1'b1, 1'b0, DATA_BUS_NONE, 8'h00, 8'h00, 0, 32'h0);
        @(negedge clk);
        tick();
        tick();
        idle();
        check_outs("reset", 0, 8'h00, 0, 0, 32'h0, 0);
        chk("reset.state", 32'(state), 32'(IDLE));

        // directed vector table (TIMEOUT = 8)
        // GPIO read, response 2 cycles after grant
        vecs.push_back('{1, DATA_BUS_GPIO, 8'h08, 8'h00, 0, 32'h0,          1, 8'h08, 0, 0, 32'h0});
        vecs.push_back('{0, DATA_BUS_NONE, 8'h00, 8'h00, 0, 32'h0,          0, 8'h00, 0, 0, 32'h0});
        vecs.push_back('{0, DATA_BUS_NONE, 8'h00, 8'h08, 3, 32'hA5A5_0001,  0, 8'h00, 1, 0, 32'hA5A5_0001});
        vecs.push_back('{0, DATA_BUS_NONE, 8'h00, 8'h00, 0, 32'h0,          0, 8'h00, 0, 0, 32'h0});
        // unmapped access; stray rvalids ignored in ERR_RESP
        vecs.push_back('{1, DATA_BUS_NONE, 8'h00, 8'h00, 0, 32'h0,          1, 8'h00, 0, 0, 32'h0});
        vecs.push_back('{0, DATA_BUS_NONE, 8'h00, 8'hFF, 0, 32'h1111_1111,  0, 8'h00, 1, 1, 32'h0});
        vecs.push_back('{0, DATA_BUS_NONE, 8'h00, 8'h00, 0, 32'h0,          0, 8'h00, 0, 0, 32'h0});
        // data RAM grant held off 3 cycles; second request during WAIT_RESP not forwarded
        vecs.push_back('{1, DATA_BUS_DATA_RAM, 8'h00, 8'h00, 0, 32'h0,      0, 8'h04, 0, 0, 32'h0});
        vecs.push_back('{1, DATA_BUS_DATA_RAM, 8'h00, 8'h00, 0, 32'h0,      0, 8'h04, 0, 0, 32'h0});
        vecs.push_back('{1, DATA_BUS_DATA_RAM, 8'h00, 8'h00, 0, 32'h0,      0, 8'h04, 0, 0, 32'h0});
        vecs.push_back('{1, DATA_BUS_DATA_RAM, 8'h04, 8'h00, 0, 32'h0,      1, 8'h04, 0, 0, 32'h0});
        vecs.push_back('{1, DATA_BUS_SPI,  8'hFF, 8'h00, 0, 32'h0,          0, 8'h00, 0, 0, 32'h0});
        vecs.push_back('{1, DATA_BUS_SPI,  8'hFF, 8'h01, 0, 32'h0000_0BAD,  0, 8'h00, 0, 0, 32'h0});
        vecs.push_back('{0, DATA_BUS_NONE, 8'h00, 8'h04, 2, 32'h1234_5678,  0, 8'h00, 1, 0, 32'h1234_5678});
        vecs.push_back('{0, DATA_BUS_NONE, 8'h00, 8'h04, 2, 32'h1234_5678,  0, 8'h00, 0, 0, 32'h0});
        // rvalid exactly at the timeout limit (cycle 7 after grant)
        vecs.push_back('{1, DATA_BUS_GPIO, 8'h08, 8'h00, 0, 32'h0,          1, 8'h08, 0, 0, 32'h0});
        for (int k = 1; k <= TO - 2; k++) begin
            vecs.push_back('{0, DATA_BUS_NONE, 8'h00, 8'h00, 0, 32'h0,      0, 8'h00, 0, 0, 32'h0});
        end
        vecs.push_back('{0, DATA_BUS_NONE, 8'h00, 8'h08, 3, 32'hCAFE_0007,  0, 8'h00, 1, 0, 32'hCAFE_0007});
        vecs.push_back('{0, DATA_BUS_NONE, 8'h00, 8'h00, 0, 32'h0,          0, 8'h00, 0, 0, 32'h0});

        for (int v = 0; v < vecs.size(); v++) begin
            drive(1'b0, vecs[v].req, vecs[v].sel, vecs[v].gnt, vecs[v].rv, vecs[v].rd_idx, vecs[v].rd);
            check_outs($sformatf("vec%0d", v), vecs[v].e_gnt, vecs[v].e_sreq,
                       vecs[v].e_rv, vecs[v].e_err, vecs[v].e_rd, 1'b0);
            tick();
        end

        // stalled UART: error response at cycle TO-1 after grant, late rvalid ignored
        drive(1'b0, 1'b1, DATA_BUS_UART, 8'h20, 8'h00, 0, 32'h0);
        check_outs("stall.grant", 1, 8'h20, 0, 0, 32'h0, 0);
        tick();
        for (int k = 1; k < TO - 1; k++) begin
            idle();
            check_outs($sformatf("stall.wait%0d", k), 0, 8'h00, 0, 0, 32'h0, 0);
            tick();
        end
        idle();
        check_outs("stall.timeout", 0, 8'h00, 1, 1, 32'h0, 0);
        tick();
        drive(1'b0, 1'b0, DATA_BUS_NONE, 8'h00, 8'h20, 5, 32'h5555_5555);
        check_outs("stall.late", 0, 8'h00, 0, 0, 32'h0, 1);
        tick();
        idle();
        check_outs("stall.sticky", 0, 8'h00, 0, 0, 32'h0, 1);
        tick();

        // reset in WAIT_RESP drops the transaction
        drive(1'b0, 1'b1, DATA_BUS_GPIO, 8'h08, 8'h00, 0, 32'h0);
        check_outs("rstmid.grant", 1, 8'h08, 0, 0, 32'h0, 1);
        tick();
        idle();
        check_outs("rstmid.wait", 0, 8'h00, 0, 0, 32'h0, 1);
        tick();
        drive(1'b1, 1'b0, DATA_BUS_NONE, 8'h00, 8'h00, 0, 32'h0);
        tick();
        drive(1'b0, 1'b0, DATA_BUS_NONE, 8'h00, 8'h08, 3, 32'h7777_7777);
        check_outs("rstmid.after", 0, 8'h00, 0, 0, 32'h0, 0);
        chk("rstmid.state", 32'(state), 32'(IDLE));
        tick();
        drive(1'b0, 1'b1, DATA_BUS_GPIO, 8'h08, 8'h00, 0, 32'h0);
        check_outs("rstmid.req2", 1, 8'h08, 0, 0, 32'h0, 0);
        tick();
        drive(1'b0, 1'b0, DATA_BUS_NONE, 8'h00, 8'h08, 3, 32'h0000_4242);
        check_outs("rstmid.resp2", 0, 8'h00, 1, 0, 32'h0000_4242, 0);
        tick();

        // random traffic against the reference model
        drive(1'b1, 1'b0, DATA_BUS_NONE, 8'h00, 8'h00, 0, 32'h0);
        tick();
        m_busy = 0; m_errp = 0; m_ts = 0; m_idx = 0; m_age = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic            r, q, e_gnt, e_rv, e_err, ts_next;
            data_bus_slave_t s;
            logic [7:0]      g, rv, e_sreq;
            logic [31:0]     e_rd;
            logic [32:0]     got;
            r = ($urandom_range(0, 249) == 0);
            q = ($urandom_range(0, 9) < 6);
            s = data_bus_slave_t'($urandom_range(0, 8));
            g = 8'($urandom_range(0, 255));
            for (int i = 0; i < NS; i++) begin
                rv[i] = ($urandom_range(0, 5) == 0);
            end
            rst = r; core_req = q; requested_slave = s; slave_gnt = g; slave_rvalid = rv;
            for (int i = 0; i < NS; i++) begin
                slave_rdata[i] = $urandom;
            end
            #1;
            if (r) begin
                m_busy = 0; m_errp = 0; m_ts = 0;
                exp_q.delete();
            end else begin
                e_gnt = 0; e_sreq = 8'h00; e_rv = 0; e_err = 0; e_rd = 32'h0;
                ts_next = m_ts;
                if (m_errp) begin
                    e_rv = 1; e_err = 1; m_errp = 0;
                end else if (m_busy) begin
                    if (rv[m_idx]) begin
                        e_rv = 1; e_rd = slave_rdata[m_idx]; m_busy = 0;
                    end else if (m_age == TO - 1) begin
                        e_rv = 1; e_err = 1; m_busy = 0; ts_next = 1;
                    end else begin
                        m_age++;
                    end
                end else if (q) begin
                    if (s == DATA_BUS_NONE) begin
                        e_gnt = 1; m_errp = 1;
                    end else begin
                        e_sreq[int'(s) - 1] = 1'b1;
                        e_gnt = g[int'(s) - 1];
                        if (e_gnt) begin
                            m_busy = 1; m_idx = int'(s) - 1; m_age = 1;
                        end
                    end
                end
                if (e_rv) begin
                    exp_q.push_back({e_err, e_rd});
                end
                chk("rnd.gnt",       32'(core_gnt),     32'(e_gnt));
                chk("rnd.slave_req", 32'(slave_req),    32'(e_sreq));
                chk("rnd.rvalid",    32'(core_rvalid),  32'(e_rv));
                chk("rnd.timeout",   32'(timeout_seen), 32'(m_ts));
                if (core_rvalid) begin
                    if (exp_q.size() == 0) begin
                        chk("rnd.unexpected_rvalid", 32'(core_rvalid), 32'h0);
                    end else begin
                        got = exp_q.pop_front();
                        chk("rnd.err",   32'(core_err), 32'(got[32]));
                        chk("rnd.rdata", core_rdata,    got[31:0]);
                    end
                end
                m_ts = ts_next;
            end
            tick();
        end
        chk("final.queue_empty", 32'(exp_q.size()), 32'h0);

        // final report
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
